mult16_seq_ctrl: RTL and testbench
==================================

Name: mult16_seq_ctrl

Overview:
- Multi-cycle 16x16 unsigned multiplier sequencer that time-shares a single mult8x8 array across four phases instead of instantiating four.
- Captures operands on a valid/ready handshake and accumulates shifted 8x8 partial products into a 32-bit register.
- Presents the product on a valid/ready output handshake.
- Sits in the CPU execute path as the area-reduced alternative to the combinational 16x16 multiplier; same operand/product widths.

Parameters:
- HALF_W, 8, width of the shared sub-multiplier operands; the operand width is 2*HALF_W and the product width is 4*HALF_W. Only 8 is supported in this release.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  global advance enable; low freezes the FSM, accumulator and phase counter
- in_valid  input  1  operands A/B valid
- in_ready  output  1  block can accept operands
- A  input  16  multiplicand
- B  input  16  multiplier
- out_valid  output  1  P valid
- out_ready  input  1  consumer accepts P
- P  output  32  unsigned product A*B
- busy  output  1  high in MUL or DONE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, phase=0, accumulator=0, operand regs=0, in_ready=1, out_valid=0, P=0, busy=0. Reset mid-operation aborts with no output.
- States and transitions:
  - IDLE: in_ready=1. On enable & in_valid, latch A,B, clear accumulator, phase=0, go to MUL.
  - MUL: one phase per enabled cycle; acc += pp << shift.
    - phase0: A[7:0]*B[7:0], shift 0
    - phase1: A[7:0]*B[15:8], shift 8
    - phase2: A[15:8]*B[7:0], shift 8
    - phase3: A[15:8]*B[15:8], shift 16
  - After phase3, go to DONE.
  - DONE: out_valid=1, P=accumulator. On out_ready, go to IDLE (in_ready rises the next cycle; no same-cycle re-accept).
- Latency: acceptance edge, then 4 enabled edges; out_valid is high in the 5th cycle after acceptance when enable stays high. Throughput is 1 result per 5 cycles minimum plus the output wait.
- enable=0: all state holds and outputs hold. While enable=0, in_ready stays as dictated by state but no capture occurs. out_valid is held, and out_ready is ignored while enable=0.
- Arithmetic: unsigned. The accumulator is 32 bits and cannot overflow, since the maximum is 0xFFFF*0xFFFF=0xFFFE0001. Partial-product adds use a 32-bit zero-extended addend.
- P is registered (the accumulator) and stable for the whole of DONE. A/B changes after capture have no effect.
- in_valid during MUL/DONE: ignored; the requester must hold it until in_ready.
- out_valid and in_ready are never high together.

Optional Feature:
- Macro: MULT_ZERO_SKIP_EN.
- Defined: in IDLE, if A==0 or B==0 at acceptance, the block bypasses MUL and enters DONE directly with P=0. out_valid is high on the cycle after acceptance.
- Undefined: all operands take the full 4 phases.

Decomposition:
- Shared package mult_pkg holds:
  - state enum {IDLE, MUL, DONE}
  - HALF_W, OP_W=16 and PROD_W=32 constants
  - phase-to-shift constants (0, 8, 8, 16)
- Sub-module: the existing mult8x8, instantiated once. Its operand muxes are driven by phase.
- The FSM and accumulator stay in mult16_seq_ctrl.

Test Plan:
- Reset mid-op: assert rst_n=0 during phase2 -> out_valid=0, busy=0, in_ready=1 immediately; the next op 3*5 returns P=0x0000000F.
- Basic: A=0x1234, B=0x5678, enable=1, out_ready=1 -> out_valid exactly 5 cycles after acceptance, P=0x06260060, then in_ready=1 the following cycle.
- Max: A=0xFFFF, B=0xFFFF -> P=0xFFFE0001. With A=0x8000, B=0x0002 -> P=0x00010000 (carry across halves).
- Backpressure: out_ready=0 for 10 cycles after DONE -> P and out_valid stable; in_ready=0 throughout; a new in_valid with A=7 is not captured until after the handshake.
- Enable stall: drop enable for 3 cycles during phase1 of 0x00FF*0x0100 -> latency grows by 3, P=0x0000FF00.
- Zero operand: A=0, B=0xABCD -> P=0. With MULT_ZERO_SKIP_EN, out_valid is high 1 cycle after acceptance; without it, 5 cycles after.

Source files
------------

// File: rtl/mult_pkg.sv
// mult_pkg -- shared constants and types for the sequential 16x16 multiplier.
//
// Contents:
//   HALF_W, OP_W, PROD_W   : sub-multiplier, operand and product widths
//   state_t                : sequencer state encoding {IDLE, MUL, DONE}
//   SHIFT_P0..SHIFT_P3     : left shift applied to each phase's partial product
//   phase_shift()          : maps a 2-bit phase index to its shift amount
package mult_pkg;

   localparam int HALF_W = 8;
   localparam int OP_W   = 2 * HALF_W;
   localparam int PROD_W = 4 * HALF_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Phase order: lo*lo, lo(A)*hi(B), hi(A)*lo(B), hi*hi
   localparam logic [4:0] SHIFT_P0 = 5'd0;
   localparam logic [4:0] SHIFT_P1 = 5'd8;
   localparam logic [4:0] SHIFT_P2 = 5'd8;
   localparam logic [4:0] SHIFT_P3 = 5'd16;

   function automatic logic [4:0] phase_shift(input logic [1:0] phase);
      logic [4:0] sh;
      case (phase)
         2'd0:    sh = SHIFT_P0;
         2'd1:    sh = SHIFT_P1;
         2'd2:    sh = SHIFT_P2;
         default: sh = SHIFT_P3;
      endcase
      return sh;
   endfunction

endpackage

// File: rtl/mult16_seq_ctrl_if.sv
// mult16_seq_ctrl_if -- operand/product handshake bundle for mult16_seq_ctrl.
//
// Signals:
//   in_valid / in_ready   : operand handshake (A, B transfer when both high)
//   A, B                  : 16-bit unsigned operands
//   out_valid / out_ready : product handshake
//   P                     : 32-bit unsigned product
//   busy                  : multiplier is working or holding a result
// Modports:
//   master : requester side (drives operands, accepts product)
//   slave  : multiplier side
interface mult16_seq_ctrl_if;
   import mult_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [OP_W-1:0]   A;
   logic [OP_W-1:0]   B;
   logic              out_valid;
   logic              out_ready;
   logic [PROD_W-1:0] P;
   logic              busy;

   modport master (
      output in_valid, A, B, out_ready,
      input  in_ready, out_valid, P, busy
   );

   modport slave (
      input  in_valid, A, B, out_ready,
      output in_ready, out_valid, P, busy
   );

endinterface

// File: rtl/mult8x8.sv
// mult8x8 -- combinational unsigned W x W multiplier (shift-and-add array).
//
// Ports:
//   a, b : W-bit unsigned operands
//   p    : 2W-bit unsigned product
module mult8x8 #(
   parameter int W = 8
) (
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic [2*W-1:0] p
);

   logic [2*W-1:0] row [W];

   // One gated, shifted copy of a per bit of b
   genvar gi;
   generate
      for (gi = 0; gi < W; gi++) begin : g_row
         assign row[gi] = b[gi] ? ({{W{1'b0}}, a} << gi) : '0;
      end
   endgenerate

   always_comb begin
      p = '0;
      for (int i = 0; i < W; i++) begin
         p = p + row[i];
      end
   end

endmodule

// File: rtl/mult16_seq_ctrl.sv
// mult16_seq_ctrl -- 16x16 unsigned multiplier that reuses one 8x8 array over
// four phases, accumulating shifted partial products into a 32-bit register.
//
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset (aborts any operation, no output)
//   enable : global advance enable; low freezes state, phase and accumulator
//   bus    : mult16_seq_ctrl_if.slave (in_valid/in_ready/A/B,
//            out_valid/out_ready/P, busy)
//
// Optional build macro:
//   MULT_ZERO_SKIP_EN : when defined, a zero operand at acceptance jumps
//                       straight to DONE with P=0 (result one cycle later).
//
// Latency with enable held high: acceptance edge plus four phase edges, so
// out_valid rises on the fifth edge counted from acceptance.
module mult16_seq_ctrl #(
   parameter int HALF_W = mult_pkg::HALF_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable,
   mult16_seq_ctrl_if.slave   bus
);
   import mult_pkg::*;

   state_t                 state_reg;
   logic [1:0]             phase_reg;
   logic [4*HALF_W-1:0]    acc_reg;
   logic [2*HALF_W-1:0]    a_reg;
   logic [2*HALF_W-1:0]    b_reg;
   logic                   in_ready_reg;
   logic                   out_valid_reg;
   logic                   busy_reg;

   logic [HALF_W-1:0]      mult_a;
   logic [HALF_W-1:0]      mult_b;
   logic [2*HALF_W-1:0]    pp;
   logic [4*HALF_W-1:0]    addend;
   logic [4*HALF_W-1:0]    acc_next;
   logic                   skip_mul;

   // phase[1] selects the A half, phase[0] the B half
   assign mult_a = phase_reg[1] ? a_reg[2*HALF_W-1:HALF_W] : a_reg[HALF_W-1:0];
   assign mult_b = phase_reg[0] ? b_reg[2*HALF_W-1:HALF_W] : b_reg[HALF_W-1:0];

   mult8x8 #(
      .W (HALF_W)
   ) u_mult8x8 (
      .a (mult_a),
      .b (mult_b),
      .p (pp)
   );

   // Zero-extend before shifting so the hi*hi term cannot lose bits
   assign addend   = {{(2*HALF_W){1'b0}}, pp} << phase_shift(phase_reg);
   assign acc_next = acc_reg + addend;

`ifdef MULT_ZERO_SKIP_EN
   assign skip_mul = (bus.A == '0) || (bus.B == '0);
`else
   assign skip_mul = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         phase_reg     <= '0;
         acc_reg       <= '0;
         a_reg         <= '0;
         b_reg         <= '0;
         in_ready_reg  <= 1'b1;
         out_valid_reg <= 1'b0;
         busy_reg      <= 1'b0;
      end else if (enable) begin
         case (state_reg)
            IDLE: begin
               if (bus.in_valid) begin
                  a_reg        <= bus.A;
                  b_reg        <= bus.B;
                  acc_reg      <= '0;
                  phase_reg    <= '0;
                  in_ready_reg <= 1'b0;
                  busy_reg     <= 1'b1;
                  if (skip_mul) begin
                     state_reg     <= DONE;
                     out_valid_reg <= 1'b1;
                  end else begin
                     state_reg <= MUL;
                  end
               end
            end
            MUL: begin
               acc_reg   <= acc_next;
               phase_reg <= phase_reg + 2'd1;
               if (phase_reg == 2'd3) begin
                  state_reg     <= DONE;
                  out_valid_reg <= 1'b1;
               end
            end
            DONE: begin
               // in_ready only rises after the edge that completes the
               // output handshake, so no operand is taken in the same cycle
               if (bus.out_ready) begin
                  state_reg     <= IDLE;
                  out_valid_reg <= 1'b0;
                  busy_reg      <= 1'b0;
                  in_ready_reg  <= 1'b1;
               end
            end
            default: begin
               state_reg     <= IDLE;
               in_ready_reg  <= 1'b1;
               out_valid_reg <= 1'b0;
               busy_reg      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_reg;
   assign bus.out_valid = out_valid_reg;
   assign bus.busy      = busy_reg;
   // The accumulator is the product register; it only changes outside DONE
   assign bus.P         = acc_reg;

endmodule

// File: tb/tb_mult16_seq_ctrl.sv
// tb_mult16_seq_ctrl -- self-checking bench for mult16_seq_ctrl.
// Expected products are pushed to a scoreboard queue on acceptance and popped
// when the DUT presents out_valid. Build with MULT_ZERO_SKIP_EN to exercise
// the zero-operand shortcut.
module tb_mult16_seq_ctrl;

   logic clk    = 1'b0;
   logic rst_n  = 1'b0;
   logic enable = 1'b0;

   mult16_seq_ctrl_if bus ();

   mult16_seq_ctrl dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .enable (enable),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [31:0] p;
   } txn_t;

   txn_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

`ifdef MULT_ZERO_SKIP_EN
   localparam int ZERO_LAT = 1;
`else
   localparam int ZERO_LAT = 5;
`endif

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge. Returns at the negedge after the acceptance edge.
   task automatic send(input logic [15:0] a, input logic [15:0] b);
      txn_t t;
      bit   ok;
      ok = 1'b0;
      bus.in_valid = 1'b1;
      bus.A        = a;
      bus.B        = b;
      for (int i = 0; i < 200; i++) begin
         if (bus.in_ready && enable) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         check_val("accept_timeout", 32'd0, 32'd1);
      end else begin
         t.a = a;
         t.b = b;
         t.p = 32'(a) * 32'(b);
         sb_q.push_back(t);
      end
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   // Latency counts edges from the acceptance edge (=1) to the edge that
   // raised out_valid. Optional output back-pressure and enable stall.
   task automatic recv(input int exp_lat, input int hold, input int stall_at, input int stall_len);
      txn_t t;
      int   cnt;
      cnt = 1;
      bus.out_ready = (hold == 0);
      check_val("busy_after_accept", 32'(bus.busy), 32'd1);
      check_val("in_ready_after_accept", 32'(bus.in_ready), 32'(bus.out_valid ? 0 : 0));
      while (!bus.out_valid && cnt < 200) begin
         if (stall_len > 0 && cnt == stall_at) enable = 1'b0;
         if (stall_len > 0 && cnt == stall_at + stall_len) enable = 1'b1;
         @(negedge clk);
         cnt++;
      end
      enable = 1'b1;
      if (!bus.out_valid) begin
         check_val("out_timeout", 32'(bus.out_valid), 32'd1);
         return;
      end
      if (sb_q.size() == 0) begin
         check_val("sb_empty", 32'd0, 32'd1);
         return;
      end
      t = sb_q.pop_front();
      check_val("latency", 32'(cnt), 32'(exp_lat));
      check_val("product", bus.P, t.p);
      check_val("in_ready_in_done", 32'(bus.in_ready), 32'd0);
      if (hold > 0) begin
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_val("hold_valid", 32'(bus.out_valid), 32'd1);
            check_val("hold_p", bus.P, t.p);
            check_val("hold_in_ready", 32'(bus.in_ready), 32'd0);
         end
         // out_ready must be ignored while enable is low
         enable        = 1'b0;
         bus.out_ready = 1'b1;
         repeat (2) @(negedge clk);
         check_val("disabled_out_ready_ignored", 32'(bus.out_valid), 32'd1);
         check_val("disabled_p", bus.P, t.p);
         enable = 1'b1;
      end
      bus.out_ready = 1'b1;
      $display("TXN A=%04h B=%04h P=%08h lat=%0d", t.a, t.b, bus.P, cnt);
      @(posedge clk);
      @(negedge clk);
      check_val("out_valid_after_hs", 32'(bus.out_valid), 32'd0);
      check_val("in_ready_after_hs", 32'(bus.in_ready), 32'd1);
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.A         = '0;
      bus.B         = '0;
      bus.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      check_val("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check_val("rst_busy", 32'(bus.busy), 32'd0);
      check_val("rst_p", bus.P, 32'd0);
      rst_n  = 1'b1;
      enable = 1'b1;
      @(negedge clk);

      // Basic and boundary products
      send(16'h1234, 16'h5678); recv(5, 0, 0, 0);
      send(16'hFFFF, 16'hFFFF); recv(5, 0, 0, 0);
      send(16'h8000, 16'h0002); recv(5, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         send(16'($urandom_range(1, 16'hFFFF)), 16'($urandom_range(1, 16'hFFFF)));
         recv(5, 0, 0, 0);
      end

      // Back-pressure with a pending request that must wait
      send(16'h1111, 16'h2222);
      bus.in_valid = 1'b1;
      bus.A        = 16'd7;
      bus.B        = 16'd9;
      recv(5, 10, 0, 0);
      send(16'd7, 16'd9); recv(5, 0, 0, 0);

      // Enable dropped for 3 cycles while phase1 is pending
      send(16'h00FF, 16'h0100); recv(8, 0, 2, 3);

      // Zero operands
      send(16'h0000, 16'hABCD); recv(ZERO_LAT, 0, 0, 0);
      send(16'h1234, 16'h0000); recv(ZERO_LAT, 0, 0, 0);

      // Reset during phase2 aborts with no output
      send(16'h1234, 16'h1111);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_val("abort_out_valid", 32'(bus.out_valid), 32'd0);
      check_val("abort_busy", 32'(bus.busy), 32'd0);
      check_val("abort_in_ready", 32'(bus.in_ready), 32'd1);
      sb_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send(16'd3, 16'd5); recv(5, 0, 0, 0);
      check_val("final_p", bus.P, 32'h0000000F);

      check_val("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
